// File: rtl/mem_sweep_ctrl.sv
// rtl/mem_sweep_ctrl.sv - memory sweep controller: reads an address range and streams the data
//
// Reads every size-aligned location from addr_begin_i to addr_end_i (inclusive),
// one read outstanding at a time, and forwards each read word on a ready/valid stream.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   start_i, addr_begin_i,
//   addr_end_i, size_i            sweep request, sampled while idle
//   mem_req_o/addr_o/size_o,
//   mem_gnt_i/rvalid_i/rdata_i/
//   mem_err_i                     single-port read memory interface
//   out_valid_o/data_o/last_o,
//   out_ready_i                   read-data stream
//   busy_o, done_o, error_o,
//   err_addr_o                    status (error_o/err_addr_o sticky until next accepted start)
//   checksum_o                    running 32-bit sum of streamed data, only with MEM_SWEEP_CHECKSUM_EN
//
// Optional feature macro: MEM_SWEEP_CHECKSUM_EN

module mem_sweep_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] addr_begin_i,
    input  logic [ADDR_W-1:0] addr_end_i,
    input  logic [1:0]        size_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [1:0]        mem_size_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W-1:0] err_addr_o
`ifdef MEM_SWEEP_CHECKSUM_EN
    ,
    output logic [31:0]       checksum_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [1:0]        size_q, size_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
`ifdef MEM_SWEEP_CHECKSUM_EN
    logic [31:0]       checksum_q, checksum_d;
`endif

    logic [ADDR_W-1:0] step_w;
    logic              last_w;
    logic              start_ok_w;
    logic              aligned_w;

    // Distance-based last test: stays correct when addr + step would wrap past 2^ADDR_W.
    assign step_w = ADDR_ONE << size_q;
    assign last_w = (end_q - addr_q) < step_w;

    always_comb begin
        aligned_w = 1'b1;
        case (size_i)
            2'd1:    aligned_w = (addr_begin_i[0] == 1'b0);
            2'd2:    aligned_w = (addr_begin_i[1:0] == 2'b00);
            2'd3:    aligned_w = (addr_begin_i[2:0] == 3'b000);
            default: aligned_w = 1'b1;
        endcase
    end

    assign start_ok_w = aligned_w && (addr_end_i >= addr_begin_i);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        end_d      = end_q;
        size_d     = size_q;
        data_d     = data_q;
        done_d     = 1'b0;
        error_d    = error_q;
        err_addr_d = err_addr_q;
`ifdef MEM_SWEEP_CHECKSUM_EN
        checksum_d = checksum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
`ifdef MEM_SWEEP_CHECKSUM_EN
                    checksum_d = '0;
`endif
                    if (start_ok_w) begin
                        addr_d     = addr_begin_i;
                        end_d      = addr_end_i;
                        size_d     = size_i;
                        error_d    = 1'b0;
                        err_addr_d = '0;
                        state_d    = ST_REQ;
                    end else begin
                        // Rejected range: report it without touching memory.
                        error_d    = 1'b1;
                        err_addr_d = addr_begin_i;
                        done_d     = 1'b1;
                    end
                end
            end

            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    if (mem_err_i) begin
                        error_d    = 1'b1;
                        err_addr_d = addr_q;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        data_d  = mem_rdata_i;
                        state_d = ST_OUT;
                    end
                end
            end

            ST_OUT: begin
                if (out_ready_i) begin
`ifdef MEM_SWEEP_CHECKSUM_EN
                    checksum_d = checksum_q + data_q[31:0];
`endif
                    if (last_w) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + step_w;
                        state_d = ST_REQ;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            end_q      <= '0;
            size_q     <= 2'd0;
            data_q     <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
`ifdef MEM_SWEEP_CHECKSUM_EN
            checksum_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            end_q      <= end_d;
            size_q     <= size_d;
            data_q     <= data_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
`ifdef MEM_SWEEP_CHECKSUM_EN
            checksum_q <= checksum_d;
`endif
        end
    end

    assign mem_req_o   = (state_q == ST_REQ);
    assign mem_addr_o  = addr_q;
    assign mem_size_o  = size_q;
    assign out_valid_o = (state_q == ST_OUT);
    assign out_data_o  = data_q;
    assign out_last_o  = (state_q == ST_OUT) && last_w;
    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign err_addr_o  = err_addr_q;
`ifdef MEM_SWEEP_CHECKSUM_EN
    assign checksum_o  = checksum_q;
`endif

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// tb/tb_mem_sweep_ctrl.sv - scoreboard bench for mem_sweep_ctrl

module tb_mem_sweep_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] addr_begin_i;
    logic [31:0] addr_end_i;
    logic [1:0]  size_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [1:0]  mem_size_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        mem_err_i;
    logic        out_valid_o;
    logic [63:0] out_data_o;
    logic        out_last_o;
    logic        out_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        error_o;
    logic [31:0] err_addr_o;
`ifdef MEM_SWEEP_CHECKSUM_EN
    logic [31:0] checksum_o;
`endif

    always #5 clk_i = ~clk_i;

    mem_sweep_ctrl #(.ADDR_W(32), .DATA_W(64)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .addr_begin_i (addr_begin_i),
        .addr_end_i   (addr_end_i),
        .size_i       (size_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_size_o   (mem_size_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i),
        .out_valid_o  (out_valid_o),
        .out_data_o   (out_data_o),
        .out_last_o   (out_last_o),
        .out_ready_i  (out_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .err_addr_o   (err_addr_o)
`ifdef MEM_SWEEP_CHECKSUM_EN
        ,
        .checksum_o   (checksum_o)
`endif
    );

    typedef struct packed {
        logic [63:0] d;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;

    // memory / sink model state
    bit          pend = 0;
    int          lat = 0;
    int          lat_fix = -1;
    int          gnt_wait = 0;
    int          gnt_max = 0;
    int          ready_mode = 0;
    logic        err_en = 1'b0;
    logic [31:0] err_at = '0;
    logic [31:0] gaddr = '0;
    logic [1:0]  exp_size = 2'd0;

    // stability trackers
    bit          stall_v = 0;
    logic [63:0] stall_d = '0;
    logic        stall_l = 1'b0;
    bit          req_hold = 0;
    logic [31:0] hold_a = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: observe DUT after the edge, then drive memory/sink inputs for the next edge.
    task automatic step_cycle();
        logic  re;
        beat_t bt;
        re = rst_i;
        @(posedge clk_i);
        #1;
        cyc++;
        if (done_o) done_cnt++;

        if (!re && stall_v) begin
            check("stall_valid", out_valid_o, 1);
            check("stall_data", out_data_o, stall_d);
            check("stall_last", out_last_o, stall_l);
        end
        if (!re && req_hold) begin
            check("req_hold", mem_req_o, 1);
            check("req_addr_hold", mem_addr_o, hold_a);
        end
        if (pend) check("one_outstanding", mem_req_o, 0);

        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = {$urandom, $urandom};
        if (pend) begin
            if (lat == 0) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = {32'h0, gaddr};
                mem_err_i    = err_en && (gaddr == err_at);
                pend         = 0;
            end else begin
                lat--;
            end
        end else if (mem_req_o) begin
            if (gnt_wait == 0) begin
                mem_gnt_i = 1'b1;
                gaddr     = mem_addr_o;
                pend      = 1;
                lat       = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 1));
                gnt_wait  = int'($urandom_range(0, gnt_max));
                check("mem_size", mem_size_o, exp_size);
            end else begin
                gnt_wait--;
            end
        end
        req_hold = mem_req_o && !mem_gnt_i;
        hold_a   = mem_addr_o;

        out_ready_i = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
        if (out_valid_o && out_ready_i) begin
            check("beat_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                bt = exp_q.pop_front();
                check("beat_data", out_data_o, bt.d);
                check("beat_last", out_last_o, bt.l);
            end
        end
        stall_v = out_valid_o && !out_ready_i;
        stall_d = out_data_o;
        stall_l = out_last_o;
    endtask

    task automatic run_sweep(input logic [31:0] b, input logic [31:0] e, input logic [1:0] sz,
                             input logic ee, input logic [31:0] ea,
                             input int gm, input int rm, input bit poke);
        logic [31:0] a, stp, sum;
        beat_t       bt;
        int          nd;
        bit          fin;
        stp = 32'd1 << sz;
        a   = b;
        sum = '0;
        for (int k = 0; k < 5000; k++) begin
            if (ee && a == ea) break;
            bt.d = {32'h0, a};
            bt.l = (e - a) < stp;
            exp_q.push_back(bt);
            sum += a;
            if (bt.l) break;
            a += stp;
        end
        gnt_max    = gm;
        ready_mode = rm;
        err_en     = ee;
        err_at     = ea;
        exp_size   = sz;
        nd         = done_cnt;

        start_i = 1'b1; addr_begin_i = b; addr_end_i = e; size_i = sz;
        step_cycle();
        start_i = 1'b0;
        check("req_after_start", mem_req_o, 1);
        check("addr_first", mem_addr_o, b);
        check("busy_after_start", busy_o, 1);

        fin = 0;
        for (int c = 0; c < 20000 && !fin; c++) begin
            if (poke && c == 4) begin
                start_i = 1'b1; addr_begin_i = 32'h8000; addr_end_i = 32'h8000; size_i = 2'd0;
            end
            step_cycle();
            start_i = 1'b0;
            if (done_cnt != nd) fin = 1;
        end
        check("sweep_done", fin, 1);
        check("done_pulses", done_cnt - nd, 1);
        check("busy_at_done", busy_o, 0);
        check("beats_left", exp_q.size(), 0);
        check("error_flag", error_o, ee);
        if (ee) check("err_addr", err_addr_o, ea);
`ifdef MEM_SWEEP_CHECKSUM_EN
        check("checksum", checksum_o, sum);
`endif
        exp_q.delete();
    endtask

    task automatic bad_start(input logic [31:0] b, input logic [31:0] e, input logic [1:0] sz);
        start_i = 1'b1; addr_begin_i = b; addr_end_i = e; size_i = sz;
        step_cycle();
        start_i = 1'b0;
        check("bad_done", done_o, 1);
        check("bad_no_req", mem_req_o, 0);
        check("bad_busy", busy_o, 0);
        check("bad_error", error_o, 1);
        check("bad_err_addr", err_addr_o, b);
        step_cycle();
        check("bad_done_once", done_o, 0);
        check("bad_still_idle", mem_req_o, 0);
        check("bad_error_sticky", error_o, 1);
    endtask

    initial begin
        int nd;
        bit hit;
        rst_i = 1'b1; start_i = 1'b0; addr_begin_i = '0; addr_end_i = '0; size_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; mem_err_i = 1'b0;
        out_ready_i = 1'b0;
        step_cycle();
        step_cycle();
        check("rst_req", mem_req_o, 0);
        check("rst_valid", out_valid_o, 0);
        check("rst_last", out_last_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_error", error_o, 0);
        check("rst_err_addr", err_addr_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_out_data", out_data_o, 0);
        rst_i = 1'b0;
        step_cycle();

        // full sweep, ready always, immediate grant, plus a start while busy
        run_sweep(32'h1000, 32'h11C0, 2'd2, 1'b0, 32'h0, 0, 0, 1);
        // same sweep with stalls; started in the done cycle of the previous one
        run_sweep(32'h1000, 32'h11C0, 2'd2, 1'b0, 32'h0, 3, 1, 0);
        // read error mid-sweep
        run_sweep(32'h1000, 32'h1010, 2'd2, 1'b1, 32'h1008, 1, 0, 0);
        step_cycle();
        step_cycle();
        check("error_sticky", error_o, 1);
        check("err_addr_sticky", err_addr_o, 32'h1008);

        bad_start(32'h2000, 32'h1FFC, 2'd2);
        bad_start(32'h1002, 32'h1010, 2'd2);

        // top of address space, must not wrap
        run_sweep(32'hFFFF_FFF8, 32'hFFFF_FFFF, 2'd2, 1'b0, 32'h0, 2, 1, 0);
        step_cycle();
        check("done_one_cycle", done_o, 0);
        run_sweep(32'h10, 32'h13, 2'd0, 1'b0, 32'h0, 1, 1, 0);
        run_sweep(32'h100, 32'h117, 2'd3, 1'b0, 32'h0, 0, 0, 0);
        run_sweep(32'h200, 32'h202, 2'd1, 1'b0, 32'h0, 0, 0, 0);

        // reset while waiting for read data; rvalid arrives after reset
        exp_q.delete();
        lat_fix = 2; gnt_max = 0; ready_mode = 0; exp_size = 2'd2; err_en = 1'b0;
        start_i = 1'b1; addr_begin_i = 32'h3000; addr_end_i = 32'h3010; size_i = 2'd2;
        step_cycle();
        start_i = 1'b0;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            step_cycle();
            if (pend && !mem_req_o && busy_o) hit = 1;
        end
        check("reached_wait", hit, 1);
        nd = done_cnt;
        lat = 3;
        lat_fix = -1;
        rst_i = 1'b1;
        step_cycle();
        rst_i = 1'b0;
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_req", mem_req_o, 0);
        check("mid_rst_valid", out_valid_o, 0);
        check("mid_rst_mem_addr", mem_addr_o, 0);
        for (int c = 0; c < 6; c++) step_cycle();
        check("late_rvalid_idle", busy_o, 0);
        check("late_rvalid_no_done", done_cnt - nd, 0);
        check("late_rvalid_no_beat", out_valid_o, 0);

        run_sweep(32'h1000, 32'h11C0, 2'd2, 1'b0, 32'h0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
